// File: rtl/matmul_sys_nxn_if.sv
// matmul_sys_nxn_if
//   Operand/result handshake bundle for the NxN systolic matrix multiplier.
//   Operand side : in_valid / in_ready / in_last, in_a_flat (A column k), in_b_flat (B row k).
//   Result side  : out_valid / out_ready / out_last, out_row, out_data (one C row).
//   Status       : busy.
//   Lanes are packed with lane 0 in the most significant slot.
//   modport slave  : the multiplier.
//   modport master : the producer/consumer driving it.
interface matmul_sys_nxn_if #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [N*DATA_W-1:0]     in_a_flat;
    logic [N*DATA_W-1:0]     in_b_flat;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [$clog2(N)-1:0]    out_row;
    logic [N*ACC_W-1:0]      out_data;
    logic                    busy;

    modport slave (
        input  in_valid, in_last, in_a_flat, in_b_flat, out_ready,
        output in_ready, out_valid, out_last, out_row, out_data, busy
    );

    modport master (
        output in_valid, in_last, in_a_flat, in_b_flat, out_ready,
        input  in_ready, out_valid, out_last, out_row, out_data, busy
    );
endinterface

// File: rtl/matmul_sys_nxn.sv
// matmul_sys_nxn
//   Output-stationary NxN systolic multiplier, C = A x B, signed integers.
//   One beat per cycle carries column k of A and row k of B; the input skew is
//   generated here. After the final beat the array drains, then C is streamed
//   out one row per out_valid/out_ready handshake.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any job in flight
//   bus  : matmul_sys_nxn_if.slave (operand beats, result rows, busy)
// Build option
//   MATMUL_SATURATE_EN defined   : accumulators clamp to the signed ACC_W rails,
//                                  sticky until the next job clears them.
//   MATMUL_SATURATE_EN undefined : accumulators wrap modulo 2^ACC_W.
//
// state  | meaning
// IDLE   | waiting for first beat; accepting it clears all accumulators
// LOAD   | accepting beats, bubbles inject zeros
// DRAIN  | no input; zeros flow until the farthest PE has its last product
// UNLOAD | presenting C rows 0..N-1
module matmul_sys_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int MAX_K  = 64
) (
    input  logic            clk,
    input  logic            rst,
    matmul_sys_nxn_if.slave bus
);
    localparam int RW = $clog2(N);
    localparam int BW = $clog2(MAX_K + 1);
    localparam int DW = $clog2(2 * N);
    localparam int PW = 2 * DATA_W;
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    localparam logic [BW-1:0] BEATS_INIT = BW'(MAX_K - 1);
    // Drain timer covers the 2N-2 skew/propagation cycles to PE(N-1,N-1), its
    // final accumulate, and the capture of row 0 into the output register.
    localparam logic [DW-1:0] DRAIN_INIT = DW'(2 * N - 1);

    logic [1:0]      state;
    logic [BW-1:0]   beatsLeft;
    logic [DW-1:0]   drainCnt;
    logic            accept;
    logic            lastBeat;
    logic            clearAcc;
    logic            drainDone;

    logic               outValid;
    logic               outLast;
    logic [RW-1:0]      outRow;
    logic [N*ACC_W-1:0] outData;
    logic [RW-1:0]      rowIdxNext;
    logic [N*ACC_W-1:0] rowNext;

    logic signed [DATA_W-1:0] injA [N];
    logic signed [DATA_W-1:0] injB [N];
    wire  signed [DATA_W-1:0] skewA [N];
    wire  signed [DATA_W-1:0] skewB [N];
    logic signed [DATA_W-1:0] aPipe [N][N];
    logic signed [DATA_W-1:0] bPipe [N][N];
    logic signed [ACC_W-1:0]  acc [N][N];
    logic signed [ACC_W-1:0]  accNext [N][N];

    assign bus.in_ready = (state == S_IDLE) || (state == S_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign clearAcc     = accept && (state == S_IDLE);
    assign drainDone    = (state == S_DRAIN) && (drainCnt == '0);
    // The MAX_K-th beat closes the job even without in_last.
    assign lastBeat     = bus.in_last ||
                          ((state == S_IDLE) ? (MAX_K == 1) : (beatsLeft == BW'(1)));

    // Idle/bubble cycles feed zeros so the array needs no valid bits.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            injA[i] = '0;
            injB[i] = '0;
            if (accept) begin
                injA[i] = bus.in_a_flat[(N-1-i)*DATA_W +: DATA_W];
                injB[i] = bus.in_b_flat[(N-1-i)*DATA_W +: DATA_W];
            end
        end
    end

    // Lane g of A and B is delayed g cycles before entering the array edge.
    for (genvar g = 0; g < N; g++) begin : g_skew
        if (g == 0) begin : g_direct
            assign skewA[g] = injA[g];
            assign skewB[g] = injB[g];
        end else begin : g_delay
            logic signed [DATA_W-1:0] dlyA [g];
            logic signed [DATA_W-1:0] dlyB [g];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < g; d++) begin
                        dlyA[d] <= '0;
                        dlyB[d] <= '0;
                    end
                end else begin
                    dlyA[0] <= injA[g];
                    dlyB[0] <= injB[g];
                    for (int d = 1; d < g; d++) begin
                        dlyA[d] <= dlyA[d-1];
                        dlyB[d] <= dlyB[d-1];
                    end
                end
            end
            assign skewA[g] = dlyA[g-1];
            assign skewB[g] = dlyB[g-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beatsLeft <= '0;
            drainCnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        beatsLeft <= BEATS_INIT;
                        if (lastBeat) begin
                            state    <= S_DRAIN;
                            drainCnt <= DRAIN_INIT;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        beatsLeft <= beatsLeft - BW'(1);
                        if (lastBeat) begin
                            state    <= S_DRAIN;
                            drainCnt <= DRAIN_INIT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drainCnt == '0) begin
                        state <= S_UNLOAD;
                    end else begin
                        drainCnt <= drainCnt - DW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (outValid && bus.out_ready && outLast) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Row to load into the output register on the next transfer.
    assign rowIdxNext = (state == S_DRAIN) ? '0 : (outRow + RW'(1));

    always_comb begin
        rowNext = '0;
        for (int j = 0; j < N; j++) begin
            rowNext[(N-1-j)*ACC_W +: ACC_W] = acc[rowIdxNext][j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            outRow   <= '0;
            outData  <= '0;
        end else if (drainDone) begin
            outValid <= 1'b1;
            outLast  <= 1'b0;
            outRow   <= '0;
            outData  <= rowNext;
        end else if ((state == S_UNLOAD) && outValid && bus.out_ready) begin
            if (outLast) begin
                outValid <= 1'b0;
                outLast  <= 1'b0;
                outRow   <= '0;
            end else begin
                outRow   <= rowIdxNext;
                outData  <= rowNext;
                outLast  <= (rowIdxNext == RW'(N - 1));
            end
        end
    end

    assign bus.out_valid = outValid;
    assign bus.out_last  = outLast;
    assign bus.out_row   = outRow;
    assign bus.out_data  = outData;
    assign bus.busy      = (state != S_IDLE);

`ifdef MATMUL_SATURATE_EN
    localparam logic signed [ACC_W-1:0] RAIL_HI = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RAIL_LO = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [PW-1:0] prod [N][N];
    logic signed [SW-1:0] sum [N][N];
    logic                 satFlag [N][N];
    logic                 satHit [N][N];

    // Full-precision sum, then clamp; a clamped PE stays on its rail.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j]    = PW'(aPipe[i][j]) * PW'(bPipe[i][j]);
                sum[i][j]     = SW'(acc[i][j]) + SW'(prod[i][j]);
                accNext[i][j] = acc[i][j];
                satHit[i][j]  = 1'b0;
                if (!satFlag[i][j]) begin
                    if (sum[i][j] > SW'(RAIL_HI)) begin
                        accNext[i][j] = RAIL_HI;
                        satHit[i][j]  = 1'b1;
                    end else if (sum[i][j] < SW'(RAIL_LO)) begin
                        accNext[i][j] = RAIL_LO;
                        satHit[i][j]  = 1'b1;
                    end else begin
                        accNext[i][j] = sum[i][j][ACC_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    satFlag[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    satFlag[i][j] <= clearAcc ? 1'b0 : (satFlag[i][j] || satHit[i][j]);
                end
            end
        end
    end
`else
    logic signed [ACC_W-1:0] prodW [N][N];

    // Only the low ACC_W bits survive a wrapping sum, so the product is
    // formed directly at that width.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prodW[i][j]   = ACC_W'(aPipe[i][j]) * ACC_W'(bPipe[i][j]);
                accNext[i][j] = acc[i][j] + prodW[i][j];
            end
        end
    end
`endif

    // A moves right along a row, B moves down a column, one PE per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    aPipe[i][j] <= '0;
                    bPipe[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                aPipe[i][0] <= skewA[i];
                bPipe[0][i] <= skewB[i];
                for (int j = 1; j < N; j++) begin
                    aPipe[i][j] <= aPipe[i][j-1];
                    bPipe[j][i] <= bPipe[j-1][i];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= clearAcc ? '0 : accNext[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_matmul_sys_nxn.sv
module tb_matmul_sys_nxn;
    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int MAX_K  = 4;
    localparam int CW     = N * ACC_W;
    localparam int KBUF   = 8;
    localparam longint RAIL_HI = 64'sd2147483647;
    localparam longint RAIL_LO = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_sys_nxn_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    matmul_sys_nxn #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_K(MAX_K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    int matA [N][KBUF];
    int matB [KBUF][N];
    logic [CW-1:0] expRow [N];
    int t1B [N][N] = '{'{2, 7, 9, 0}, '{0, 2, 0, 82}, '{4, 0, 2, 0}, '{0, 0, 0, 1}};

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: C[i][j] accumulated in k order with the configured reduction.
    task automatic buildExpected(input int k);
        longint a;
        longint sum;
        bit sat;
        for (int i = 0; i < N; i++) begin
            expRow[i] = '0;
            for (int j = 0; j < N; j++) begin
                a = 0;
                sat = 1'b0;
                for (int kk = 0; kk < k; kk++) begin
                    sum = a + longint'(matA[i][kk]) * longint'(matB[kk][j]);
`ifdef MATMUL_SATURATE_EN
                    if (!sat) begin
                        if (sum > RAIL_HI) begin a = RAIL_HI; sat = 1'b1; end
                        else if (sum < RAIL_LO) begin a = RAIL_LO; sat = 1'b1; end
                        else a = sum;
                    end
`else
                    a = longint'(int'(sum));
`endif
                end
                expRow[i][(N-1-j)*ACC_W +: ACC_W] = a[ACC_W-1:0];
            end
        end
    endtask

    task automatic loadT1();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                matA[i][k] = 4 * i + k + 1;
                matB[k][i] = t1B[k][i];
            end
    endtask

    function automatic int pickVal();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic driveBeat(input int kk, input bit last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        for (int l = 0; l < N; l++) begin
            bus.in_a_flat[(N-1-l)*DATA_W +: DATA_W] = matA[l][kk];
            bus.in_b_flat[(N-1-l)*DATA_W +: DATA_W] = matB[kk][l];
        end
    endtask

    task automatic sendJob(input int k, input bit bubbles);
        for (int kk = 0; kk < k; kk++) begin
            if (bubbles) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            driveBeat(kk, kk == k - 1);
            check("in_ready_load", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits for out_valid; optionally drives ignored beats while in_ready is low.
    task automatic waitResult(input bit checkLat, input bit garbage);
        int cnt;
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 200) begin
            if (garbage) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_last  = 1'($urandom_range(0, 1));
                for (int l = 0; l < N; l++) begin
                    bus.in_a_flat[l*DATA_W +: DATA_W] = $urandom;
                    bus.in_b_flat[l*DATA_W +: DATA_W] = $urandom;
                end
            end
            @(negedge clk);
            cnt++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("out_valid_timeout", bus.out_valid, 1);
        if (checkLat) check("latency", cnt, 2 * N);
    endtask

    task automatic recvRows(input bit stall);
        logic [CW-1:0] held;
        for (int r = 0; r < N; r++) begin
            if (stall) begin
                bus.out_ready = 1'b0;
                held = bus.out_data;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                check("stall_data_held", bus.out_data, held);
                check("stall_valid_held", bus.out_valid, 1);
            end
            check("row_index", bus.out_row, r);
            check("row_last", bus.out_last, (r == N - 1));
            check("row_data", bus.out_data, expRow[r]);
            check("in_ready_unload", bus.in_ready, 0);
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        check("done_valid", bus.out_valid, 0);
        check("done_busy", bus.busy, 0);
        check("done_in_ready", bus.in_ready, 1);
    endtask

    task automatic runJob(input int k, input bit bubbles, input bit stall, input bit garbage);
        buildExpected(k);
        sendJob(k, bubbles);
        waitResult(1'b1, garbage);
        recvRows(stall);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_row"}, bus.out_row, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_a_flat = '0;
        bus.in_b_flat = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: reference job, out_ready held high
        loadT1();
        runJob(4, 1'b0, 1'b0, 1'b0);

        // T2: same job with bubbles and output stalls
        runJob(4, 1'b1, 1'b1, 1'b0);

        // T3: outer product, then an immediate second job
        for (int i = 0; i < N; i++) begin
            matA[i][0] = i + 1;
            matB[0][i] = 1;
        end
        runJob(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) begin
                matA[i][k] = pickVal();
                matB[k][i] = pickVal();
            end
        runJob(2, 1'b0, 1'b0, 1'b0);

        // T4: reset during DRAIN aborts, next job is clean
        loadT1();
        sendJob(4, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkReset("t4");
        rst = 1'b0;
        @(negedge clk);
        runJob(4, 1'b0, 1'b0, 1'b0);

        // T5: extreme operands, wrap or clamp
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) begin
                matA[i][k] = 32'h7FFF_FFFF;
                matB[k][i] = 32'h7FFF_FFFF;
            end
        runJob(2, 1'b0, 1'b0, 1'b0);

        // T6: six beats without in_last, MAX_K-th beat closes the job
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) begin
                matA[i][k] = pickVal();
                matB[k][i] = pickVal();
            end
        buildExpected(MAX_K);
        for (int kk = 0; kk < 6; kk++) begin
            driveBeat(kk, 1'b0);
            check("t6_in_ready", bus.in_ready, (kk < MAX_K));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        waitResult(1'b0, 1'b0);
        recvRows(1'b0);

        // Randomised jobs with bubbles, stalls and ignored beats during drain
        for (int job = 0; job < 8; job++) begin
            int k;
            k = $urandom_range(1, MAX_K);
            for (int i = 0; i < N; i++)
                for (int kk = 0; kk < k; kk++) begin
                    matA[i][kk] = pickVal();
                    matB[kk][i] = pickVal();
                end
            runJob(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
